// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte output handshake and status between uart_rx and its consumer
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       overrun_clr;

    modport master (
        output rx_data, rx_valid, rx_frame_err, rx_overrun,
        input  rx_ready, overrun_clr
    );

    modport slave (
        input  rx_data, rx_valid, rx_frame_err, rx_overrun,
        output rx_ready, overrun_clr
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready output register
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic      system_clk,
    input  logic      reset_n,
    input  logic      uart0_rxd,
    uart_rx_if.master rx
);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] HALF  = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] FLUSH = 16'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    state_t                 state_q, next_state;
    logic [15:0]            cnt_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shreg_q;
    logic                   cnt_clr, shift_en, deliver, ferr_ev;
    logic [7:0]             data_q;
    logic                   valid_q, ferr_q, overrun_q;

    always_ff @(posedge system_clk) begin
        if (!reset_n) sync_q <= '1;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], uart0_rxd};
    end
    assign rxd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge system_clk) begin
        if (!reset_n) state_q <= WAIT_IDLE;
        else          state_q <= next_state;
    end

    // The synchroniser resets to 1, so WAIT_IDLE ignores rxd_s until the
    // reset ones have been flushed and the real pin level has arrived.
    always_comb begin
        next_state = state_q;
        case (state_q)
            WAIT_IDLE: if (rxd_s && cnt_q >= FLUSH) next_state = IDLE;
            IDLE:      if (!rxd_s) next_state = START;
            START:     if (cnt_q == HALF) next_state = rxd_s ? IDLE : DATA;
            DATA:      if (cnt_q == LAST && bit_idx_q == 3'd7) next_state = STOP;
            STOP:      if (cnt_q == LAST) next_state = rxd_s ? IDLE : WAIT_IDLE;
            default:   next_state = WAIT_IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        deliver  = 1'b0;
        ferr_ev  = 1'b0;
        case (state_q)
            DATA:    shift_en = (cnt_q == LAST);
            STOP: begin
                deliver = (cnt_q == LAST) && rxd_s;
                ferr_ev = (cnt_q == LAST) && !rxd_s;
            end
            default: ;
        endcase
        cnt_clr = (next_state != state_q) || (state_q == IDLE) || shift_en;
    end

    always_ff @(posedge system_clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            if (cnt_clr)
                cnt_q <= '0;
            else if (state_q != WAIT_IDLE || cnt_q < FLUSH)
                cnt_q <= cnt_q + 16'd1;
            if (state_q == START)
                bit_idx_q <= '0;
            else if (shift_en)
                bit_idx_q <= bit_idx_q + 3'd1;
            if (shift_en)
                shreg_q <= {rxd_s, shreg_q[7:1]};
        end
    end

    // A new byte may overwrite the register only if it is empty or being accepted now.
    always_ff @(posedge system_clk) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ferr_q <= ferr_ev;
            if (deliver && (!valid_q || rx.rx_ready)) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
            if (deliver && valid_q && !rx.rx_ready)
                overrun_q <= 1'b1;
            else if (rx.overrun_clr)
                overrun_q <= 1'b0;
        end
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_valid     = valid_q;
    assign rx.rx_frame_err = ferr_q;
    assign rx.rx_overrun   = overrun_q;
endmodule
